// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - plaintext/ciphertext streams, key-store lookup and status of the AES round sequencer
interface aes_round_ctrl_if #(parameter int N = 127);
  logic       in_valid;
  logic       in_ready;
  logic [N:0] data_in;
  logic       abort;
  logic [3:0] rk_idx;
  logic [N:0] rk_data;
  logic       out_valid;
  logic       out_ready;
  logic [N:0] data_out;
  logic       busy;
  logic [3:0] round_o;

  modport master (
    output in_valid, data_in, abort, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, data_out, busy, round_o
  );

  modport slave (
    input  in_valid, data_in, abort, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, data_out, busy, round_o
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 encryption sequencer, one full round per clock
module aes_round_ctrl #(
  parameter int N  = 127,
  parameter int NR = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  aes_round_ctrl_if.slave bus
);
  typedef logic [N:0] blk_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  localparam logic [3:0] NR_L   = 4'(NR);
  localparam logic [3:0] LAST_R = 4'(NR - 1);

  fsm_t       fsm;
  blk_t       state_reg;
  logic [3:0] rnd;
  logic       in_ready_r, out_valid_r, busy_r;
  blk_t       sr_state, mc_state;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (exponent bits 1..7 set), then the FIPS affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic blk_t sub_shift(input blk_t s);
    blk_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[N-8*(4*c+r) -: 8] = sbox(s[N-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic blk_t mix_columns(input blk_t s);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[N-32*c -: 8];
      a1 = s[N-32*c-8 -: 8];
      a2 = s[N-32*c-16 -: 8];
      a3 = s[N-32*c-24 -: 8];
      o[N-32*c -: 8]    = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[N-32*c-8 -: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[N-32*c-16 -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[N-32*c-24 -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  always_comb begin
    sr_state = sub_shift(state_reg);
    mc_state = mix_columns(sr_state);
  end

  always_comb begin
    bus.rk_idx = 4'd0;
    case (fsm)
      ROUND:   bus.rk_idx = rnd;
      FINAL:   bus.rk_idx = NR_L;
      default: bus.rk_idx = 4'd0;
    endcase
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.data_out  = state_reg;
  assign bus.round_o   = rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      state_reg   <= '0;
      rnd         <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (bus.abort && fsm != IDLE) begin
      // Cancelled block leaves state_reg untouched; only control returns to idle.
      fsm         <= IDLE;
      rnd         <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (bus.in_valid && in_ready_r) begin
          state_reg  <= bus.data_in ^ bus.rk_data;
          rnd        <= 4'd1;
          fsm        <= ROUND;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b1;
        end
        ROUND: begin
          state_reg <= mc_state ^ bus.rk_data;
          rnd       <= rnd + 4'd1;
          if (rnd == LAST_R) fsm <= FINAL;
        end
        FINAL: begin
          state_reg   <= sr_state ^ bus.rk_data;
          fsm         <= DONE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b1;
        end
        DONE: if (bus.out_ready) begin
          fsm         <= IDLE;
          rnd         <= 4'd0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - randomized self-checking bench for aes_round_ctrl against a byte-level AES model
module tb_aes_round_ctrl;
  localparam int N  = 127;
  localparam int NR = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  aes_round_ctrl_if #(.N(N)) bus ();
  aes_round_ctrl #(.N(N), .NR(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0]   sb    [256];
  logic [127:0] rk    [16];
  logic [127:0] trace [NR+1];
  int n_cmp = 0;
  int n_err = 0;

  assign bus.rk_data = rk[bus.rk_idx];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    int aa, bb, r;
    aa = a; bb = b; r = 0;
    while (bb != 0) begin
      if ((bb & 1) != 0) r = r ^ aa;
      aa = aa << 1;
      if ((aa & 256) != 0) aa = aa ^ 283;
      bb = bb >> 1;
    end
    return r[7:0];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  task automatic model(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
    trace[0] = v;
    for (int r = 1; r <= NR; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (r < NR)
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gm(t[4*c],2) ^ gm(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gm(t[4*c+1],2) ^ gm(t[4*c+2],3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2],2) ^ gm(t[4*c+3],3);
          s[4*c+3] = gm(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3],2);
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
      trace[r] = v;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_rk_idx"}, bus.rk_idx, 0);
    chk({tag, "_data_out"}, bus.data_out, 0);
    chk({tag, "_round"}, bus.round_o, 0);
  endtask

  // Called at a negedge with the controller idle; returns at a negedge.
  task automatic run_block(input logic [127:0] pt, input int bp, input int abort_at,
                           input int rst_at, input bit b2b, input bit fips);
    model(pt);
    if (fips) begin
      trace[0]  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
      trace[1]  = 128'ha49c7ff2689f352b6b5bea43026a5049;
      trace[NR] = 128'h3925841d02dc09fbdc118597196a0b32;
    end
    bus.in_valid  = 1'b1;
    bus.data_in   = pt;
    bus.out_ready = 1'b0;
    bus.abort     = 1'b0;
    chk("in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (!b2b) bus.in_valid = 1'b0;
    for (int s = 0; s <= NR; s++) begin
      if (s > 0) @(negedge clk);
      chk("state", bus.data_out, trace[s]);
      chk("out_valid", bus.out_valid, (s == NR));
      chk("busy", bus.busy, (s < NR));
      chk("in_ready_busy", bus.in_ready, 0);
      chk("round", bus.round_o, (s < NR) ? s + 1 : NR);
      chk("rk_idx", bus.rk_idx, (s < NR) ? s + 1 : 0);
      if (s == abort_at) begin
        bus.in_valid  = 1'b0;
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_round", bus.round_o, 0);
        chk("abort_state_kept", bus.data_out, trace[s]);
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_out", bus.out_valid, 0);
        end
        return;
      end
      if (s == rst_at) begin
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    repeat (bp) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_data_stable", bus.data_out, trace[NR]);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hs_out_valid", bus.out_valid, 0);
    chk("hs_in_ready", bus.in_ready, 1);
    chk("hs_no_accept_in_done", bus.data_out, trace[NR]);
  endtask

  logic [127:0] key, pt;
  int abort_at;

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    init_sbox();
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_block(128'h3243f6a8885a308d313198a2e0370734, 0, -1, -1, 1'b0, 1'b1);
    run_block(128'h3243f6a8885a308d313198a2e0370734, 5, -1, -1, 1'b0, 1'b1);
    run_block({$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, 1'b1, 1'b0);
    run_block({$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    run_block({$urandom, $urandom, $urandom, $urandom}, 0, 3, -1, 1'b0, 1'b0);
    run_block({$urandom, $urandom, $urandom, $urandom}, 1, -1, -1, 1'b0, 1'b0);
    run_block({$urandom, $urandom, $urandom, $urandom}, 0, -1, 5, 1'b0, 1'b0);
    run_block(128'h3243f6a8885a308d313198a2e0370734, 0, -1, -1, 1'b0, 1'b1);

    for (int b = 0; b < 16; b++) begin
      if (b % 4 == 0) begin
        key = {$urandom, $urandom, $urandom, $urandom};
        expand_key(key);
      end
      pt = {$urandom, $urandom, $urandom, $urandom};
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NR)) : -1;
      run_block(pt, int'($urandom_range(0, 3)), abort_at, -1, 1'($urandom_range(0, 1)), 1'b0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
